// File: rtl/accumulate_ctrl_pkg.sv
// rtl/accumulate_ctrl_pkg.sv - shared types and constants for the accumulate button controller
package accumulate_ctrl_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } deb_state_e;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd2;
  localparam logic [1:0] ADDR_DEBLIMIT = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;

endpackage

// File: rtl/accumulate_debouncer.sv
// rtl/accumulate_debouncer.sv - button synchroniser and debounce FSM producing level and edge pulses
module accumulate_debouncer
  import accumulate_ctrl_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DEB_W      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_port,
  input  logic [DEB_W-1:0] deb_limit,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  logic             in_pol;
  logic             sync_meta;
  logic             s;
  deb_state_e       state, state_nx;
  logic [DEB_W-1:0] cnt, cnt_nx;
  logic [DEB_W-1:0] lim;
  logic [DEB_W-1:0] cnt_inc;
  logic             level_nx;

  assign in_pol = ACTIVE_LOW ? ~in_port : in_port;

  // A zero limit behaves as one so the FSM can never stick in a wait state.
  assign lim     = (deb_limit == '0) ? DEB_W'(1) : deb_limit;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + DEB_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
      state     <= LOW;
      cnt       <= '0;
      level     <= 1'b0;
    end else begin
      sync_meta <= in_pol;
      s         <= sync_meta;
      state     <= state_nx;
      cnt       <= cnt_nx;
      level     <= level_nx;
    end
  end

  // Edge pulses are Mealy outputs so the capture register updates on the same edge as level.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    rise     = 1'b0;
    fall     = 1'b0;
    case (state)
      LOW: begin
        if (s) begin
          state_nx = RISE_WAIT;
          cnt_nx   = DEB_W'(1);
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else if (cnt >= lim) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          level_nx = 1'b1;
          rise     = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      HIGH: begin
        if (!s) begin
          state_nx = FALL_WAIT;
          cnt_nx   = DEB_W'(1);
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else if (cnt >= lim) begin
          state_nx = LOW;
          cnt_nx   = '0;
          level_nx = 1'b0;
          fall     = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        state_nx = LOW;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/accumulate_event_ctrl.sv
// rtl/accumulate_event_ctrl.sv - register slave with edge capture and maskable irq for the accumulate button
module accumulate_event_ctrl
  import accumulate_ctrl_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DEB_W      = 20,
  parameter int DEB_RESET  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  logic             level;
  logic             rise;
  logic             fall;
  logic             wr_en;
  logic [1:0]       irqmask;
  logic [1:0]       edgecap;
  logic [1:0]       edge_set;
  logic [1:0]       edge_clr;
  logic [DEB_W-1:0] deb_limit;
  logic [31:0]      rd_nx;
  logic             unused_wdata;

  accumulate_debouncer #(
    .ACTIVE_LOW (ACTIVE_LOW),
    .DEB_W      (DEB_W)
  ) u_deb (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .deb_limit (deb_limit),
    .level     (level),
    .rise      (rise),
    .fall      (fall)
  );

  assign wr_en = chipselect && !write_n;

  assign edge_set[EDGE_RISE] = rise;
  assign edge_set[EDGE_FALL] = fall;
  assign edge_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[1:0] : 2'b00;

  assign unused_wdata = &{1'b0, writedata[31:DEB_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask   <= 2'b00;
      edgecap   <= 2'b00;
      deb_limit <= DEB_W'(DEB_RESET);
      readdata  <= '0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK)  irqmask   <= writedata[1:0];
      if (wr_en && address == ADDR_DEBLIMIT) deb_limit <= writedata[DEB_W-1:0];
      // A capture in the same cycle as a clearing write must not be lost.
      edgecap  <= edge_set | (edgecap & ~edge_clr);
      readdata <= rd_nx;
    end
  end

  always_comb begin
    rd_nx = '0;
    case (address)
      ADDR_DATA:     rd_nx[0]         = level;
      ADDR_IRQMASK:  rd_nx[1:0]       = irqmask;
      ADDR_EDGECAP:  rd_nx[1:0]       = edgecap;
      ADDR_DEBLIMIT: rd_nx[DEB_W-1:0] = deb_limit;
      default:       rd_nx            = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_accumulate_event_ctrl.sv
// tb/tb_accumulate_event_ctrl.sv - directed self-checking bench for accumulate_event_ctrl
module tb_accumulate_event_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        in_port = 1'b1;
  logic        irq;

  int total = 0;
  int bad   = 0;

  accumulate_event_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick();
    d = readdata;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    check(name, d, exp);
  endtask

  initial begin
    vecs[0] = '{wr: 1'b0, addr: 2'd0, wdata: 32'h0,        exp: 32'h0};
    vecs[1] = '{wr: 1'b0, addr: 2'd1, wdata: 32'h0,        exp: 32'h0};
    vecs[2] = '{wr: 1'b0, addr: 2'd2, wdata: 32'h0,        exp: 32'h0};
    vecs[3] = '{wr: 1'b0, addr: 2'd3, wdata: 32'h0,        exp: 32'd50000};
    vecs[4] = '{wr: 1'b1, addr: 2'd1, wdata: 32'hFFFFFFFF, exp: 32'h3};
    vecs[5] = '{wr: 1'b1, addr: 2'd3, wdata: 32'hFFFFFFFF, exp: 32'hFFFFF};
    vecs[6] = '{wr: 1'b1, addr: 2'd0, wdata: 32'hFFFFFFFF, exp: 32'h0};
    vecs[7] = '{wr: 1'b1, addr: 2'd2, wdata: 32'hFFFFFFFF, exp: 32'h0};
    vecs[8] = '{wr: 1'b1, addr: 2'd1, wdata: 32'h0,        exp: 32'h0};
    vecs[9] = '{wr: 1'b1, addr: 2'd3, wdata: 32'd4,        exp: 32'd4};

    repeat (3) tick();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].wdata);
      read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Debounce timing with DEBLIMIT=4: irq one edge before DATA shows up on readdata.
    reg_write(2'd1, 32'h1);
    address = 2'd0;
    in_port = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("deb_irq_k%0d", k), {31'b0, irq}, {31'b0, (k >= 7)});
      check($sformatf("deb_data_k%0d", k), readdata, {31'b0, (k >= 8)});
    end
    repeat (2) tick();
    read_check("deb_edgecap_rise", 2'd2, 32'h1);
    in_port = 1'b1;
    repeat (12) tick();
    read_check("deb_edgecap_both", 2'd2, 32'h3);
    read_check("deb_data_released", 2'd0, 32'h0);
    reg_write(2'd2, 32'h3);
    check("deb_irq_cleared", {31'b0, irq}, 32'h0);
    read_check("deb_edgecap_cleared", 2'd2, 32'h0);

    // Bounce rejection: 3-clock pulses never satisfy a 5-clock stability window.
    reg_write(2'd1, 32'h3);
    for (int p = 0; p < 10; p++) begin
      in_port = (p % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick();
        check($sformatf("bounce_irq_p%0d_%0d", p, j), {31'b0, irq}, 32'h0);
      end
    end
    repeat (10) tick();
    read_check("bounce_data", 2'd0, 32'h0);
    read_check("bounce_edgecap", 2'd2, 32'h0);

    // Fall-only interrupt with DEBLIMIT=2.
    reg_write(2'd1, 32'h2);
    reg_write(2'd3, 32'd2);
    in_port = 1'b0;
    repeat (10) tick();
    check("irq_after_press", {31'b0, irq}, 32'h0);
    read_check("irq_edgecap_press", 2'd2, 32'h1);
    in_port = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("irq_release_k%0d", k), {31'b0, irq}, {31'b0, (k >= 5)});
    end
    read_check("irq_edgecap_both", 2'd2, 32'h3);
    reg_write(2'd2, 32'h2);
    check("irq_clear_fall", {31'b0, irq}, 32'h0);
    read_check("irq_edgecap_bit0", 2'd2, 32'h1);

    // Clear on the same edge as a rise capture: set wins.
    reg_write(2'd2, 32'h3);
    reg_write(2'd1, 32'h0);
    read_check("coll_pre_edgecap", 2'd2, 32'h0);
    in_port = 1'b0;
    repeat (4) tick();
    reg_write(2'd2, 32'h1);
    read_check("coll_edgecap", 2'd2, 32'h1);
    read_check("coll_data", 2'd0, 32'h1);
    in_port = 1'b1;
    repeat (10) tick();
    reg_write(2'd2, 32'h3);

    // Lowering the limit below the running count triggers on the next edge.
    reg_write(2'd1, 32'h1);
    reg_write(2'd3, 32'd100);
    in_port = 1'b0;
    repeat (20) tick();
    check("recfg_irq_before", {31'b0, irq}, 32'h0);
    reg_write(2'd3, 32'd5);
    check("recfg_irq_write_edge", {31'b0, irq}, 32'h0);
    tick();
    check("recfg_irq_next", {31'b0, irq}, 32'h1);
    in_port = 1'b1;
    repeat (15) tick();
    reg_write(2'd2, 32'h3);
    reg_write(2'd3, 32'd100);

    // Reset in the middle of a wait restores everything.
    in_port = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    read_check("rst_data", 2'd0, 32'h0);
    read_check("rst_irqmask", 2'd1, 32'h0);
    read_check("rst_edgecap", 2'd2, 32'h0);
    read_check("rst_deblimit", 2'd3, 32'd50000);
    in_port = 1'b1;
    repeat (5) tick();
    read_check("rst_data_after", 2'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
